serial_deser_8bit: RTL and testbench

Downstream consumer of the 8-bit shift register's serial_out stream. Samples framed serial bits on a per-bit strobe and checks start, parity and stop. Reassembles each good frame into a byte, either MSB-first (left-shift ops) or LSB-first (right-shift/rotate ops). Buffers reassembled bytes in a 2-entry FIFO with a valid/ready output handshake.

---
 rtl/serial_deser_8bit.sv | 179 +++++++++++++++++
 tb/tb_serial_deser_8bit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_deser_8bit.sv
// Framed serial-to-parallel receiver: start/data/parity/stop checking, per-frame bit order,
// and a small output FIFO with a registered valid/ready head.
module serial_deser_8bit #(
    parameter int unsigned DATA_W     = 8,
    parameter bit          PARITY_EN  = 1'b1,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          serial_in,
    input  logic                          bit_valid,
    input  logic                          msb_first,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow,
    input  logic                          clr_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                par_q, par_d;
    logic                par_bad_q, par_bad_d;
    logic                msb_q, msb_d;
    logic                push_c;
    logic                parity_err_d, frame_err_d;

    // Frame state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            par_q      <= 1'b0;
            par_bad_q  <= 1'b0;
            msb_q      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            par_q      <= par_d;
            par_bad_q  <= par_bad_d;
            msb_q      <= msb_d;
            parity_err <= parity_err_d;
            frame_err  <= frame_err_d;
        end
    end

    // Next-state and frame checking; everything holds on non-strobe cycles
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        par_d        = par_q;
        par_bad_d    = par_bad_q;
        msb_d        = msb_q;
        push_c       = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        if (bit_valid) begin
            case (state_q)
                IDLE: begin
                    if (serial_in == 1'b0) begin
                        msb_d     = msb_first;
                        bit_cnt_d = '0;
                        par_d     = 1'b0;
                        par_bad_d = 1'b0;
                        state_d   = DATA;
                    end
                end
                DATA: begin
                    if (msb_q) begin
                        shreg_d = {shreg_q[DATA_W-2:0], serial_in};
                    end else begin
                        shreg_d = {serial_in, shreg_q[DATA_W-1:1]};
                    end
                    par_d     = par_q ^ serial_in;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    par_bad_d = par_q ^ serial_in;
                    state_d   = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    // A bad stop bit masks any parity fault
                    if (serial_in == 1'b1) begin
                        if (par_bad_q) begin
                            parity_err_d = 1'b1;
                        end else begin
                            push_c = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  count_d;
    logic              pop_c, full_c, wr_en_c, ovf_c;
    logic [DATA_W-1:0] head_c;

    // FIFO control; the head register looks one write ahead so a push into an empty FIFO shows next cycle
    always_comb begin
        pop_c    = out_valid & out_ready;
        full_c   = (fifo_count == OCC_W'(FIFO_DEPTH));
        wr_en_c  = push_c & (~full_c | pop_c);
        ovf_c    = push_c & full_c & ~pop_c;
        rd_ptr_d = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({wr_en_c, pop_c})
            2'b10:   count_d = fifo_count + OCC_W'(1);
            2'b01:   count_d = fifo_count - OCC_W'(1);
            default: count_d = fifo_count;
        endcase
        if (wr_en_c && (wr_ptr_q == rd_ptr_d)) begin
            head_c = shreg_q;
        end else begin
            head_c = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q] <= shreg_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_count <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            rd_ptr_q   <= rd_ptr_d;
            fifo_count <= count_d;
            out_valid  <= (count_d != '0);
            if (count_d != '0) begin
                out_data <= head_c;
            end
            if (ovf_c) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_deser_8bit.sv
// Directed bench for serial_deser_8bit: frame reception, error pulses, FIFO full/overflow, async reset.
module tb_serial_deser_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in;
    logic       bit_valid;
    logic       msb_first;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;
    logic       clr_overflow;
    logic [1:0] fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    serial_deser_8bit dut (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .bit_valid    (bit_valid),
        .msb_first    (msb_first),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One strobe: drive at a falling edge, return at the next falling edge
    task automatic strobe(input logic b);
        serial_in = b;
        bit_valid = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
        serial_in = 1'b1;
    endtask

    // Full frame; returns at the falling edge right after the stop-bit strobe edge
    task automatic send_frame(input logic [7:0] data, input logic msb, input logic par_flip,
                              input logic stop_bit, input int gap, input logic ready_on_stop);
        logic prev_ready;
        logic par;
        par = (^data) ^ par_flip;
        msb_first = msb;
        strobe(1'b0);
        msb_first = ~msb;
        repeat (gap) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            strobe(msb ? data[7-i] : data[i]);
            repeat (gap) @(negedge clk);
        end
        strobe(par);
        repeat (gap) @(negedge clk);
        prev_ready = out_ready;
        if (ready_on_stop) out_ready = 1'b1;
        strobe(stop_bit);
        out_ready = prev_ready;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        serial_in    = 1'b1;
        bit_valid    = 1'b0;
        msb_first    = 1'b0;
        out_ready    = 1'b0;
        clr_overflow = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid",  32'(out_valid),  32'h0);
        check("rst_out_data",   32'(out_data),   32'h0);
        check("rst_fifo_count", 32'(fifo_count), 32'h0);
        check("rst_overflow",   32'(overflow),   32'h0);
        check("rst_errs",       32'({parity_err, frame_err}), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // 1: 0xA5 LSB-first, no gaps
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        check("t1_data",  32'(out_data),   32'hA5);
        check("t1_valid", 32'(out_valid),  32'h1);
        check("t1_count", 32'(fifo_count), 32'h1);
        check("t1_errs",  32'({parity_err, frame_err}), 32'h0);
        pop_one();
        check("t1_pop_valid", 32'(out_valid),  32'h0);
        check("t1_pop_count", 32'(fifo_count), 32'h0);

        // 2: 0xB6 MSB-first with 3-cycle gaps; msb_first flipped after start
        send_frame(8'hB6, 1'b1, 1'b0, 1'b1, 3, 1'b0);
        check("t2_data",  32'(out_data),  32'hB6);
        check("t2_valid", 32'(out_valid), 32'h1);
        pop_one();

        // 3: parity fault, stop fault, both faults
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        check("t3_perr",       32'({parity_err, frame_err}), 32'h2);
        check("t3_perr_count", 32'(fifo_count), 32'h0);
        check("t3_perr_valid", 32'(out_valid),  32'h0);
        @(negedge clk);
        check("t3_perr_pulse_end", 32'(parity_err), 32'h0);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        check("t3_ferr",       32'({parity_err, frame_err}), 32'h1);
        check("t3_ferr_count", 32'(fifo_count), 32'h0);
        @(negedge clk);
        check("t3_ferr_pulse_end", 32'(frame_err), 32'h0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        check("t3_both", 32'({parity_err, frame_err}), 32'h1);

        // 4: fill past capacity, then drain and clear overflow
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        check("t4_ovf_before", 32'(overflow), 32'h0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        send_frame(8'h33, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        check("t4_count", 32'(fifo_count), 32'h2);
        check("t4_ovf",   32'(overflow),   32'h1);
        check("t4_head",  32'(out_data),   32'h11);
        pop_one();
        check("t4_head2",  32'(out_data),   32'h22);
        check("t4_count1", 32'(fifo_count), 32'h1);
        pop_one();
        check("t4_empty",      32'(out_valid), 32'h0);
        check("t4_ovf_sticky", 32'(overflow),  32'h1);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        check("t4_ovf_clr", 32'(overflow), 32'h0);

        // 5: push and pop on the same edge while full
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        check("t5_full", 32'(fifo_count), 32'h2);
        send_frame(8'h44, 1'b0, 1'b0, 1'b1, 0, 1'b1);
        check("t5_count", 32'(fifo_count), 32'h2);
        check("t5_head",  32'(out_data),   32'h22);
        check("t5_ovf",   32'(overflow),   32'h0);
        pop_one();
        check("t5_head44", 32'(out_data), 32'h44);
        pop_one();
        check("t5_empty", 32'(out_valid), 32'h0);

        // 6: async reset mid-frame with a full FIFO and overflow set
        send_frame(8'h77, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        send_frame(8'h66, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        check("t6_pre_ovf",   32'(overflow),   32'h1);
        check("t6_pre_count", 32'(fifo_count), 32'h2);
        msb_first = 1'b0;
        strobe(1'b0);
        strobe(1'b1);
        strobe(1'b0);
        strobe(1'b1);
        strobe(1'b1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(out_valid),  32'h0);
        check("t6_rst_data",  32'(out_data),   32'h0);
        check("t6_rst_count", 32'(fifo_count), 32'h0);
        check("t6_rst_ovf",   32'(overflow),   32'h0);
        check("t6_rst_errs",  32'({parity_err, frame_err}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        check("t6_data",  32'(out_data),   32'h5A);
        check("t6_valid", 32'(out_valid),  32'h1);
        check("t6_count", 32'(fifo_count), 32'h1);
        check("t6_errs",  32'({parity_err, frame_err}), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
